// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                funct3 opcodes, FSM state encoding, default widths and
//                operand-signedness helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    // Default datapath and register-address widths
    localparam int c_xlen_default    = 32;
    localparam int c_raddr_w_default = 5;

    // funct3 operation codes
    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_mulhu  = 3'd3;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    // One-hot FSM state encoding
    typedef enum logic [2:0] {
        c_st_idle = 3'b001,
        c_st_calc = 3'b010,
        c_st_end  = 3'b100
    } state_t;

    // Divide/remainder ops all have funct3 bit 2 set
    function automatic logic f_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // op_a is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic f_a_signed(input logic [2:0] op);
        return (op == c_op_mulh) || (op == c_op_mulhsu) ||
               (op == c_op_div)  || (op == c_op_rem);
    endfunction

    // op_b is treated as signed for MULH, DIV and REM
    function automatic logic f_b_signed(input logic [2:0] op);
        return (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative RV-style multiply/divide unit. Radix-2 shift-add
//                multiply and radix-2 restoring divide on operand magnitudes,
//                sharing one XLEN+1-bit adder/subtractor. Divide-by-zero and
//                signed overflow bypass the iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = c_xlen_default,
    parameter int RADDR_W = c_raddr_w_default
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [2:0]         op_i,
    input  logic [XLEN-1:0]    op_a_i,
    input  logic [XLEN-1:0]    op_b_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    output logic [XLEN-1:0]    result_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [RADDR_W-1:0] reg_waddr_o
);

    localparam int                 c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);

    state_t               r_state;
    logic [2:0]           r_op;
    logic [RADDR_W-1:0]   r_waddr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [XLEN-1:0]      r_hi;        // partial product high half / remainder
    logic [XLEN-1:0]      r_lo;        // multiplier bits / dividend-quotient
    logic [XLEN-1:0]      r_opnd;      // multiplicand or divisor magnitude
    logic                 r_neg_res;   // negate product or quotient at the end
    logic                 r_neg_rem;   // negate remainder at the end

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [XLEN-1:0]      w_a_mag;
    logic [XLEN-1:0]      w_b_mag;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic                 w_special;
    logic                 w_accept;

    logic [XLEN:0]        w_add_a;
    logic [XLEN:0]        w_add_b;
    logic                 w_add_sub;
    logic [XLEN:0]        w_add_res;

    logic [2*XLEN-1:0]    w_prod;
    logic [2*XLEN-1:0]    w_prod_fix;
    logic [XLEN-1:0]      w_quo;
    logic [XLEN-1:0]      w_rem;
    logic [XLEN-1:0]      w_result;

    // Request decode: operand signs, magnitudes and the bypass cases
    always_comb begin
        w_a_neg    = f_a_signed(op_i) & op_a_i[XLEN-1];
        w_b_neg    = f_b_signed(op_i) & op_b_i[XLEN-1];
        w_a_mag    = w_a_neg ? -op_a_i : op_a_i;
        w_b_mag    = w_b_neg ? -op_b_i : op_b_i;
        w_div_zero = (op_b_i == '0);
        w_ovf      = (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
        // Overflow only exists for the signed divide ops
        w_special  = f_is_div(op_i) & (w_div_zero | (w_ovf & f_b_signed(op_i)));
        w_accept   = (r_state == c_st_idle) & start_i & ~flush_i;
    end

    // Shared adder/subtractor: conditional add for multiply, trial subtract for divide
    always_comb begin
        if (f_is_div(r_op)) begin
            w_add_a   = {r_hi, r_lo[XLEN-1]};
            w_add_b   = {1'b0, r_opnd};
            w_add_sub = 1'b1;
        end else begin
            w_add_a   = {1'b0, r_hi};
            w_add_b   = r_lo[0] ? {1'b0, r_opnd} : '0;
            w_add_sub = 1'b0;
        end
        w_add_res = w_add_a + (w_add_b ^ {(XLEN+1){w_add_sub}}) + {{XLEN{1'b0}}, w_add_sub};
    end

    // Final sign fix-up and result selection
    always_comb begin
        w_prod     = {r_hi, r_lo};
        w_prod_fix = r_neg_res ? -w_prod : w_prod;
        w_quo      = r_neg_res ? -r_lo : r_lo;
        w_rem      = r_neg_rem ? -r_hi : r_hi;
        case (r_op)
            c_op_mul:                            w_result = w_prod_fix[XLEN-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu:  w_result = w_prod_fix[2*XLEN-1:XLEN];
            c_op_div, c_op_divu:                 w_result = w_quo;
            c_op_rem, c_op_remu:                 w_result = w_rem;
            default:                             w_result = w_rem;
        endcase
    end

    // Datapath: load on accept, then one multiply/divide step per CALC cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= op_i;
            r_waddr <= reg_waddr_i;
            r_cnt   <= '0;
            if (f_is_div(op_i)) begin
                if (w_special) begin
                    // Preload the bypass answer so END selects it unchanged:
                    // quotient lives in r_lo, remainder in r_hi.
                    r_neg_res <= 1'b0;
                    r_neg_rem <= 1'b0;
                    r_lo      <= w_div_zero ? '1 : op_a_i;
                    r_hi      <= w_div_zero ? op_a_i : '0;
                end else begin
                    r_hi      <= '0;
                    r_lo      <= w_a_mag;
                    r_opnd    <= w_b_mag;
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                end
            end else begin
                r_hi      <= '0;
                r_lo      <= w_b_mag;
                r_opnd    <= w_a_mag;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= 1'b0;
            end
        end else if (r_state == c_st_calc) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (f_is_div(r_op)) begin
                // Negative trial difference means restore the shifted remainder
                r_hi <= w_add_res[XLEN] ? w_add_a[XLEN-1:0] : w_add_res[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], ~w_add_res[XLEN]};
            end else begin
                r_hi <= w_add_res[XLEN:1];
                r_lo <= {w_add_res[0], r_lo[XLEN-1:1]};
            end
        end
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= c_st_idle;
            result_o    <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                r_state <= c_st_idle;
                busy_o  <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start_i) begin
                            r_state <= w_special ? c_st_end : c_st_calc;
                            busy_o  <= 1'b1;
                        end
                    end
                    c_st_calc: begin
                        if (r_cnt == c_cnt_last) begin
                            r_state <= c_st_end;
                        end
                    end
                    c_st_end: begin
                        r_state     <= c_st_idle;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        result_o    <= w_result;
                        reg_waddr_o <= r_waddr;
                    end
                    default: begin
                        r_state <= c_st_idle;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Self-checking bench for ex_muldiv. A cycle-level reference
//                model (plain wide arithmetic plus a latency countdown) is
//                compared against a 32-bit instance every cycle; directed
//                literal cases and a 64-bit instance cover the corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rstn, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] op_a_i, op_b_i, result_o;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic        done_o, busy_o;

    // 64-bit instance
    logic        rstn64, start64, flush64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, res64;
    logic [4:0]  waddr64_i, waddr64_o;
    logic        done64, busy64;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ex_muldiv #(.XLEN(32), .RADDR_W(5)) u_dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .flush_i(flush_i),
        .op_i(op_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .reg_waddr_i(reg_waddr_i),
        .result_o(result_o), .done_o(done_o), .busy_o(busy_o), .reg_waddr_o(reg_waddr_o)
    );

    ex_muldiv #(.XLEN(64), .RADDR_W(5)) u_dut64 (
        .clk(clk), .rstn(rstn64), .start_i(start64), .flush_i(flush64),
        .op_i(op64), .op_a_i(a64), .op_b_i(b64), .reg_waddr_i(waddr64_i),
        .result_o(res64), .done_o(done64), .busy_o(busy64), .reg_waddr_o(waddr64_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result: operands sign/zero-extended into wide integers
    function automatic logic [63:0] ref_result(input int w, input logic [2:0] op,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] one, mask, au, bu, as_, bs, mn, r;
        one  = 130'sd1;
        mask = (one <<< w) - one;
        au   = $signed({66'd0, a}) & mask;
        bu   = $signed({66'd0, b}) & mask;
        as_  = au;
        bs   = bu;
        if (au[w-1]) as_ = au - (one <<< w);
        if (bu[w-1]) bs  = bu - (one <<< w);
        mn   = -(one <<< (w - 1));
        case (op)
            3'd0: r = au * bu;
            3'd1: r = (as_ * bs) >>> w;
            3'd2: r = (as_ * bu) >>> w;
            3'd3: r = (au * bu) >>> w;
            3'd4: begin
                if (bu == 0)                   r = mask;
                else if (as_ == mn && bs == -1) r = au;
                else                           r = as_ / bs;
            end
            3'd5: r = (bu == 0) ? mask : au / bu;
            3'd6: begin
                if (bu == 0)                   r = au;
                else if (as_ == mn && bs == -1) r = '0;
                else                           r = as_ % bs;
            end
            default: r = (bu == 0) ? au : au % bu;
        endcase
        r = r & mask;
        return r[63:0];
    endfunction

    // Bypass cases finish in two cycles instead of XLEN+2
    function automatic logic ref_special(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        if (op < 3'd4)   return 1'b0;
        if (b == 32'd0)  return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle-level reference model and per-cycle comparison of the 32-bit DUT
    initial begin : p_compare
        int          m_left;
        logic        m_done;
        logic [31:0] m_res, m_pend;
        logic [4:0]  m_wad, m_pend_w;
        logic [63:0] tmp;
        m_left = 0; m_done = 1'b0; m_res = '0; m_pend = '0; m_wad = '0; m_pend_w = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rstn) begin
                m_left = 0; m_done = 1'b0; m_res = '0; m_wad = '0;
            end else begin
                m_done = 1'b0;
                if (flush_i) begin
                    m_left = 0;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        m_res  = m_pend;
                        m_wad  = m_pend_w;
                    end
                end else if (start_i) begin
                    tmp      = ref_result(32, op_i, {32'd0, op_a_i}, {32'd0, op_b_i});
                    m_pend   = tmp[31:0];
                    m_pend_w = reg_waddr_i;
                    m_left   = ref_special(op_i, op_a_i, op_b_i) ? 1 : 33;
                end
            end
            @(negedge clk);
            check("busy",  64'(busy_o),      64'(m_left > 0));
            check("done",  64'(done_o),      64'(m_done));
            check("result", 64'(result_o),   64'(m_res));
            check("waddr", 64'(reg_waddr_o), 64'(m_wad));
        end
    end

    // Directed operation with hand-computed result and latency
    task automatic dir_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] w,
                          input logic [31:0] lit, input int lat);
        start_i = 1'b1; op_i = op; op_a_i = a; op_b_i = b; reg_waddr_i = w;
        step();
        start_i = 1'b0;
        check({name, "_busy_c1"}, 64'(busy_o), 64'd1);
        repeat (lat - 2) step();
        check({name, "_early_done"}, 64'(done_o), 64'd0);
        step();
        check({name, "_done"},   64'(done_o),      64'd1);
        check({name, "_busy"},   64'(busy_o),      64'd0);
        check({name, "_result"}, 64'(result_o),    64'(lit));
        check({name, "_waddr"},  64'(reg_waddr_o), 64'(w));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin : p_main
        logic saw;
        rstn = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        op_a_i = '0; op_b_i = '0; reg_waddr_i = '0;
        rstn64 = 1'b1; start64 = 1'b0; flush64 = 1'b0; op64 = '0;
        a64 = '0; b64 = '0; waddr64_i = '0;
        repeat (3) step();
        rstn = 1'b0; rstn64 = 1'b0;
        check("rst_result", 64'(result_o),    64'd0);
        check("rst_busy",   64'(busy_o),      64'd0);
        check("rst_done",   64'(done_o),      64'd0);
        check("rst_waddr",  64'(reg_waddr_o), 64'd0);

        // Pin the reference model to hand-computed values
        check("model_div",    ref_result(32, 3'd4, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFD);
        check("model_rem",    ref_result(32, 3'd6, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF);
        check("model_mulh",   ref_result(32, 3'd1, 64'h8000_0000, 64'h8000_0000), 64'h4000_0000);
        check("model_mulhsu", ref_result(32, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 64'hFFFF_FFFF);
        check("model_divu64", ref_result(64, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3),
              64'h5555_5555_5555_5555);

        // Directed cases, issued back-to-back in each done cycle
        dir_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,           5'd3,  32'hFFFF_FFFD, 34);
        dir_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,           5'd4,  32'hFFFF_FFFF, 34);
        dir_op("divu_zero", 3'd5, 32'd5,         32'd0,           5'd5,  32'hFFFF_FFFF, 2);
        dir_op("remu_zero", 3'd7, 32'd5,         32'd0,           5'd6,  32'd5,         2);
        dir_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF,   5'd7,  32'h8000_0000, 2);
        dir_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF,   5'd8,  32'd0,         2);
        dir_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000,   5'd9,  32'h4000_0000, 34);
        dir_op("mul_min",   3'd0, 32'h8000_0000, 32'h8000_0000,   5'd10, 32'd0,         34);
        dir_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,   5'd11, 32'hFFFF_FFFF, 34);
        dir_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,   5'd12, 32'hFFFF_FFFE, 34);

        // Flush a DIV in its cycle 10, then restart in cycle 11
        start_i = 1'b1; op_i = 3'd4; op_a_i = 32'd100; op_b_i = 32'd7; reg_waddr_i = 5'd13;
        step();
        start_i = 1'b0;
        repeat (9) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy",   64'(busy_o),      64'd0);
        check("flush_done",   64'(done_o),      64'd0);
        check("flush_result", 64'(result_o),    64'hFFFF_FFFE);
        check("flush_waddr",  64'(reg_waddr_o), 64'd12);
        dir_op("after_flush", 3'd5, 32'd1000, 32'd7, 5'd14, 32'd142, 34);

        // Randomised traffic: starts, ignored starts, flushes and rare resets
        for (int i = 0; i < 3000; i++) begin
            rstn        = ($urandom_range(0, 599) == 0);
            start_i     = ($urandom_range(0, 3) == 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            op_i        = 3'($urandom_range(0, 7));
            op_a_i      = pick();
            op_b_i      = pick();
            reg_waddr_i = 5'($urandom_range(0, 31));
            step();
        end
        rstn = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        repeat (40) step();

        // 64-bit instance: long divide latency, then reset mid-operation
        start64 = 1'b1; op64 = 3'd5; a64 = '1; b64 = 64'd3; waddr64_i = 5'd21;
        step();
        start64 = 1'b0;
        check("d64_busy_c1", 64'(busy64), 64'd1);
        repeat (64) step();
        check("d64_early_done", 64'(done64), 64'd0);
        step();
        check("d64_done",   64'(done64),    64'd1);
        check("d64_result", res64,          64'h5555_5555_5555_5555);
        check("d64_waddr",  64'(waddr64_o), 64'd21);
        step();
        start64 = 1'b1; op64 = 3'd4; a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'd5; waddr64_i = 5'd22;
        step();
        start64 = 1'b0;
        repeat (19) step();
        rstn64 = 1'b1;
        step();
        rstn64 = 1'b0;
        check("r64_result", res64,          64'd0);
        check("r64_busy",   64'(busy64),    64'd0);
        check("r64_done",   64'(done64),    64'd0);
        check("r64_waddr",  64'(waddr64_o), 64'd0);
        saw = 1'b0;
        repeat (80) begin
            step();
            if (done64) saw = 1'b1;
        end
        check("r64_no_done", 64'(saw), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
